// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the RISC-V fetch stage.
//
// Chooses the next PC each cycle from the sequential, branch, indirect-jump,
// return and trap sources. Includes a stall enable, a 4-byte alignment check on
// the computed target, and a circular return-address stack (RAS) used to
// predict function returns.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   en         advance enable (0 = stall); a trap is taken regardless
//   sel        next-PC source: 000 seq, 001 branch, 010 jalr, 011 ret, 1xx hold
//   trap       trap request, highest priority
//   trap_vec   trap handler address (low two bits forced to zero)
//   pc_ex      PC of the instruction in EX (branch base)
//   imm        sign-extended immediate
//   rs1        rs1 operand (jalr base)
//   ras_push   push push_addr onto the RAS
//   push_addr  return address to push
//   pc         registered current PC
//   misalign   one-cycle pulse: the last computed target was not 4-byte aligned
//   ras_top    current RAS top entry, 0 when the RAS is empty
//   ras_empty  RAS holds no entries
//   ras_full   RAS holds RAS_DEPTH entries
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [2:0]      sel,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            ras_push,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] pc,
    output logic            misalign,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Registered state
    logic [XLEN-1:0]  pc_reg,       pc_next;
    logic             misalign_reg, misalign_next;
    logic [PTR_W-1:0] top_reg,      top_next;
    logic [CNT_W-1:0] count_reg,    count_next;

    // RAS storage; only entries covered by count_reg are ever observed, so the
    // array itself needs no reset.
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

    // RAS write port
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    // Target formation
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  jalr_target;
    logic             has_target;
    logic             do_pop;

    // -------------------------------------------------------------------------
    // RAS status
    // -------------------------------------------------------------------------
    assign ras_empty = (count_reg == '0);
    assign ras_full  = (count_reg == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[top_reg];

    assign pc        = pc_reg;
    assign misalign  = misalign_reg;

    assign jalr_target = (rs1 + imm) & ~XLEN'(1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        pc_next       = pc_reg;
        misalign_next = 1'b0;
        top_next      = top_reg;
        count_next    = count_reg;
        wr_en         = 1'b0;
        wr_idx        = top_reg;
        target        = pc_reg + XLEN'(4);
        has_target    = 1'b0;
        do_pop        = 1'b0;

        if (trap) begin
            // Trap vector is forced word-aligned, so no alignment check applies.
            pc_next = trap_vec & ~XLEN'(3);
        end else if (en) begin
            case (sel)
                3'b000: begin
                    target     = pc_reg + XLEN'(4);
                    has_target = 1'b1;
                end
                3'b001: begin
                    target     = pc_ex + imm;
                    has_target = 1'b1;
                end
                3'b010: begin
                    target     = jalr_target;
                    has_target = 1'b1;
                end
                3'b011: begin
                    // Predicted return when the stack has an entry; otherwise
                    // fall back to the architectural jalr target.
                    has_target = 1'b1;
                    if (!ras_empty) begin
                        target = ras_mem[top_reg];
                        do_pop = 1'b1;
                    end else begin
                        target = jalr_target;
                    end
                end
                default: begin
                    has_target = 1'b0;
                end
            endcase

            if (has_target && (target[1:0] != 2'b00)) begin
                // Misaligned target: hold pc and suppress all RAS activity.
                misalign_next = 1'b1;
            end else begin
                if (has_target) begin
                    pc_next = target;
                end
                if (do_pop && ras_push) begin
                    // Return followed immediately by a call: swap the top entry.
                    wr_en  = 1'b1;
                    wr_idx = top_reg;
                end else if (do_pop) begin
                    top_next   = top_reg - PTR_W'(1);
                    count_next = count_reg - CNT_W'(1);
                end else if (ras_push) begin
                    // When full, top+1 is the oldest entry, which gets overwritten.
                    wr_en    = 1'b1;
                    wr_idx   = top_reg + PTR_W'(1);
                    top_next = top_reg + PTR_W'(1);
                    if (!ras_full) begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_VECTOR;
            misalign_reg <= 1'b0;
            top_reg      <= '0;
            count_reg    <= '0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
            top_reg      <= top_next;
            count_reg    <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= push_addr;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
// Directed scenarios followed by randomized cycles, compared against a
// queue-based reference model of the PC and return-address stack.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic [2:0]      sel = 3'b000;
    logic            trap = 1'b0;
    logic [XLEN-1:0] trap_vec = '0;
    logic [XLEN-1:0] pc_ex = '0;
    logic [XLEN-1:0] imm = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic            ras_push = 1'b0;
    logic [XLEN-1:0] push_addr = '0;
    logic [XLEN-1:0] pc;
    logic            misalign;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sel       (sel),
        .trap      (trap),
        .trap_vec  (trap_vec),
        .pc_ex     (pc_ex),
        .imm       (imm),
        .rs1       (rs1),
        .ras_push  (ras_push),
        .push_addr (push_addr),
        .pc        (pc),
        .misalign  (misalign),
        .ras_top   (ras_top),
        .ras_empty (ras_empty),
        .ras_full  (ras_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = RV;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    // Apply the architectural rules for one clock edge using the current inputs.
    task automatic model_step();
        logic [31:0] t;
        logic [31:0] fallback;
        bit          has_t;
        bit          pop;
        fallback = (rs1 + imm) & 32'hFFFF_FFFE;
        if (trap) begin
            m_pc  = (trap_vec / 4) * 4;
            m_mis = 1'b0;
        end else if (!en) begin
            m_mis = 1'b0;
        end else begin
            has_t = 1'b1;
            pop   = 1'b0;
            t     = m_pc;
            case (sel)
                3'd0: t = m_pc + 32'd4;
                3'd1: t = pc_ex + imm;
                3'd2: t = fallback;
                3'd3: begin
                    if (m_ras.size() > 0) begin
                        t   = m_ras[$];
                        pop = 1'b1;
                    end else begin
                        t = fallback;
                    end
                end
                default: has_t = 1'b0;
            endcase
            if (has_t && (t % 4 != 0)) begin
                m_mis = 1'b1;
            end else begin
                m_mis = 1'b0;
                if (has_t) m_pc = t;
                if (pop && ras_push) begin
                    m_ras[m_ras.size()-1] = push_addr;
                end else if (pop) begin
                    void'(m_ras.pop_back());
                end else if (ras_push) begin
                    m_ras.push_back(push_addr);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] exp_top;
        exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
        check_eq({tag, ".pc"},        pc,                 m_pc);
        check_eq({tag, ".misalign"},  {31'b0, misalign},  {31'b0, m_mis});
        check_eq({tag, ".ras_top"},   ras_top,            exp_top);
        check_eq({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
        check_eq({tag, ".ras_full"},  {31'b0, ras_full},  {31'b0, m_ras.size() == DEPTH});
    endtask

    // One clock: model the edge, let the DUT take it, then compare away from it.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic set_in(input logic e, input logic [2:0] s, input logic t,
                          input logic p, input logic [31:0] pa);
        en = e; sel = s; trap = t; ras_push = p; push_addr = pa;
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from RESET_VECTOR
        set_in(1, 3'b000, 0, 0, 0);
        tick("seq0"); check_eq("seq0.lit", pc, 32'h104);
        tick("seq1"); check_eq("seq1.lit", pc, 32'h108);
        tick("seq2"); check_eq("seq2.lit", pc, 32'h10C);

        // Branch then stall
        pc_ex = 32'h200; imm = 32'hFFFF_FFF8;
        set_in(1, 3'b001, 0, 0, 0);
        tick("branch"); check_eq("branch.lit", pc, 32'h1F8);
        set_in(0, 3'b000, 0, 1, 32'h55);
        tick("stall0");
        tick("stall1"); check_eq("stall.lit", pc, 32'h1F8);

        // jalr misaligned, then aligned
        rs1 = 32'h301; imm = 32'h2;
        set_in(1, 3'b010, 0, 0, 0);
        tick("jalr_mis"); check_eq("jalr_mis.lit", {31'b0, misalign}, 32'h1);
        imm = 32'h3;
        tick("jalr_ok"); check_eq("jalr_ok.lit", pc, 32'h304);

        // Five pushes into a 4-deep RAS (pc held via reserved sel)
        for (int i = 1; i <= 5; i++) begin
            set_in(1, 3'b100, 0, 1, 32'(i * 16));
            tick($sformatf("push%0d", i));
        end
        check_eq("push.full", {31'b0, ras_full}, 32'h1);

        // Five returns: four predicted, last one falls back to jalr
        rs1 = 32'h400; imm = 32'h8;
        for (int i = 1; i <= 5; i++) begin
            set_in(1, 3'b011, 0, 0, 0);
            tick($sformatf("ret%0d", i));
        end
        check_eq("ret.fallback", pc, 32'h408);

        // Trap during stall ignores push
        set_in(1, 3'b100, 0, 1, 32'h40);
        tick("push40");
        trap_vec = 32'h803;
        set_in(0, 3'b011, 1, 1, 32'h77);
        tick("trap"); check_eq("trap.lit", pc, 32'h800);

        // Simultaneous pop and push
        set_in(1, 3'b011, 0, 1, 32'h90);
        tick("swap"); check_eq("swap.top", ras_top, 32'h90);

        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized operation
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            sel       = 3'($urandom_range(0, 7) < 6 ? $urandom_range(0, 3) : $urandom_range(4, 7));
            trap      = ($urandom_range(0, 19) == 0);
            trap_vec  = $urandom;
            pc_ex     = $urandom & 32'hFFFF_FFFC;
            imm       = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rs1       = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ras_push  = ($urandom_range(0, 2) == 0);
            push_addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tick($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
